// File: rtl/pwm_tach_interface_pkg.sv
// Shared definitions for the PWM / tachometer speed interface.
// Optional feature macro: TACH_FILTER_EN (tach glitch filter, see tach_edge_detect).
package pwm_tach_interface_pkg;

   // Width of pw / C / R, common with the speed controller.
   localparam int unsigned SPEED_W = 8;
   // Edge counter is one bit wider so it can hold the saturation value 256.
   localparam int unsigned EDGE_W  = SPEED_W + 1;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StPublish
   } state_e;

   // Clamp a window edge count to the 8-bit speed range.
   function automatic logic [SPEED_W-1:0] sat_speed(input logic [EDGE_W-1:0] cnt);
      return (cnt > EDGE_W'(255)) ? '1 : cnt[SPEED_W-1:0];
   endfunction

endpackage

// File: rtl/pwm_tach_interface_tach_edge_detect.sv
// Tach input conditioning: synchronizer, optional glitch filter, rising-edge pulse.
// With TACH_FILTER_EN defined the synchronized level must be stable for FILT_LEN
// consecutive samples before it is accepted; otherwise every synchronized edge counts.
module tach_edge_detect
   import pwm_tach_interface_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tach_in,
   output logic edge_pulse
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end
   if (FILT_LEN < 1) begin : g_bad_filt
      $error("FILT_LEN must be at least 1");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   logic                   level;
   logic                   level_q;

   // Metastability chain for the asynchronous tach pin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], tach_in};
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef TACH_FILTER_EN
   localparam int unsigned FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

   logic [FW-1:0] filt_cnt_q;
   logic          filt_q;

   // Accept a new level only after FILT_LEN consecutive differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_cnt_q <= '0;
         filt_q     <= 1'b0;
      end else if (sync_out != filt_q) begin
         if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
            filt_q     <= sync_out;
            filt_cnt_q <= '0;
         end else begin
            filt_cnt_q <= filt_cnt_q + FW'(1);
         end
      end else begin
         filt_cnt_q <= '0;
      end
   end

   assign level = filt_q;
`else
   assign level = sync_out;
`endif

   // Registered one-cycle pulse on each rising edge of the conditioned level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q    <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         level_q    <= level;
         edge_pulse <= level & ~level_q;
      end
   end

endmodule

// File: rtl/pwm_tach_interface.sv
// Plant-side end of the speed loop: motor PWM from duty command pw, and measured
// speed C = tach rising edges per GATE_CYCLES window (saturated at 255).
// Optional feature macro: TACH_FILTER_EN (enables the tach glitch filter).
module pwm_tach_interface
   import pwm_tach_interface_pkg::*;
#(
   parameter int unsigned PWM_MAX     = 255,
   parameter int unsigned GATE_CYCLES = 100,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               go,
   input  logic [SPEED_W-1:0] pw,
   input  logic               tach_in,
   output logic               pwm_out,
   output logic [SPEED_W-1:0] C,
   output logic               c_valid,
   output logic               c_sat
);

   if (GATE_CYCLES < 2) begin : g_bad_gate
      $error("GATE_CYCLES must be at least 2");
   end

   localparam int unsigned PCW = (PWM_MAX > 1) ? $clog2(PWM_MAX) : 1;
   localparam int unsigned GCW = $clog2(GATE_CYCLES);

   state_e             state_q;
   logic [PCW-1:0]     pwm_cnt_q;
   logic [SPEED_W-1:0] shadow_q;
   logic [GCW-1:0]     gate_cnt_q;
   logic [EDGE_W-1:0]  edge_cnt_q;

   logic               edge_pulse;
   logic               running;
   logic               gate_end;
   logic               pwm_wrap;
   logic [EDGE_W-1:0]  edge_sum;
   logic [SPEED_W-1:0] duty;

   tach_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
   ) u_tach_edge_detect (
      .clk        (clk),
      .rst_n      (rst_n),
      .tach_in    (tach_in),
      .edge_pulse (edge_pulse)
   );

   assign running  = go && (state_q != StIdle);
   assign gate_end = (state_q == StRun) && (gate_cnt_q == GCW'(GATE_CYCLES - 1));
   assign pwm_wrap = (pwm_cnt_q == PCW'(PWM_MAX - 1));

   // Count including this cycle's edge, sticking at 256 so overflow stays visible.
   assign edge_sum = (edge_pulse && (edge_cnt_q != EDGE_W'(256))) ?
                     edge_cnt_q + EDGE_W'(1) : edge_cnt_q;

   // At period start the fresh pw is used directly so the shadow load costs no cycle.
   assign duty = (pwm_cnt_q == '0) ? pw : shadow_q;

   // Gate FSM: back-to-back windows; the closing cycle's edge lands in the closing window,
   // and the PUBLISH cycle doubles as gate cycle 0 of the next window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         C          <= '0;
         c_valid    <= 1'b0;
         c_sat      <= 1'b0;
      end else begin
         c_valid <= 1'b0;
         if (!go) begin
            state_q    <= StIdle;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            c_sat      <= 1'b0;
         end else begin
            case (state_q)
               StIdle: begin
                  state_q <= StRun;
               end
               StRun: begin
                  if (gate_end) begin
                     state_q    <= StPublish;
                     C          <= sat_speed(edge_sum);
                     c_valid    <= 1'b1;
                     c_sat      <= c_sat | (edge_sum > EDGE_W'(255));
                     gate_cnt_q <= '0;
                     edge_cnt_q <= '0;
                  end else begin
                     gate_cnt_q <= gate_cnt_q + GCW'(1);
                     edge_cnt_q <= edge_sum;
                  end
               end
               StPublish: begin
                  state_q    <= StRun;
                  gate_cnt_q <= gate_cnt_q + GCW'(1);
                  edge_cnt_q <= edge_sum;
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   // PWM counter, period-aligned duty shadow and registered compare output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt_q <= '0;
         shadow_q  <= '0;
         pwm_out   <= 1'b0;
      end else if (!running) begin
         pwm_cnt_q <= '0;
         pwm_out   <= 1'b0;
      end else begin
         if (pwm_cnt_q == '0) begin
            shadow_q <= pw;
         end
         pwm_cnt_q <= pwm_wrap ? '0 : pwm_cnt_q + PCW'(1);
         pwm_out   <= 32'(pwm_cnt_q) < 32'(duty);
      end
   end

endmodule

// File: tb/tb_pwm_tach_interface.sv
// Bench for pwm_tach_interface: directed steps plus randomized pw/tach segments, checked
// every cycle against a cycle-indexed reference model of the PWM periods and gate windows.
// Honours TACH_FILTER_EN (glitch filter) when the design is built with it.
module tb_pwm_tach_interface;

   localparam int G1   = 100;
   localparam int G2   = 1000;
   localparam int PMAX = 255;
   localparam int SYNC = 2;
   localparam int FILT = 4;
`ifdef TACH_FILTER_EN
   localparam int LAT     = SYNC + 1 + FILT;
   localparam int HL      = FILT + 2;
   localparam int EXP_P5  = 0;
   localparam int T4_PER  = 2 * FILT;
   localparam int T4_C    = 125;
   localparam int T4_SAT  = 0;
`else
   localparam int LAT     = SYNC + 1;
   localparam int HL      = 2;
   localparam int EXP_P5  = 20;
   localparam int T4_PER  = 2;
   localparam int T4_C    = 255;
   localparam int T4_SAT  = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       go = 1'b0;
   logic       go2 = 1'b0;
   logic       tach = 1'b0;
   logic [7:0] pw = 8'd0;
   logic       pwm1, cv1, sat1, pwm2, cv2, sat2;
   logic [7:0] c1, c2;

   always #5 clk = ~clk;

   pwm_tach_interface #(
      .PWM_MAX(PMAX), .GATE_CYCLES(G1), .SYNC_STAGES(SYNC), .FILT_LEN(FILT)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .go(go), .pw(pw), .tach_in(tach),
      .pwm_out(pwm1), .C(c1), .c_valid(cv1), .c_sat(sat1)
   );

   pwm_tach_interface #(
      .PWM_MAX(PMAX), .GATE_CYCLES(G2), .SYNC_STAGES(SYNC), .FILT_LEN(FILT)
   ) u_dut_long (
      .clk(clk), .rst_n(rst_n), .go(go2), .pw(pw), .tach_in(tach),
      .pwm_out(pwm2), .C(c2), .c_valid(cv2), .c_sat(sat2)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int rises[$];      // pin cycle at which each accepted tach rise began
   int pw_hist[int];  // pw value present during each cycle
   int rs1 = -1;      // cycle in which go was first seen high for the current run
   int rs2 = -1;
   int cm1 = 0;
   int cm2 = 0;
   bit sm1 = 1'b0;
   bit sm2 = 1'b0;
   bit tach_prev = 1'b0;
   int tper = 0;
   int thigh = 0;
   int t0 = 0;
   int first_cv1 = -1;
   int flev = 0;
   int frun = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Edges whose detection pulse falls inside window k of a run that started at rs.
   function automatic int win_count(input int rs, input int g, input int k);
      int lo = rs + 1 + k * g;
      int hi = rs + (k + 1) * g;
      int n = 0;
      foreach (rises[i]) if (rises[i] + LAT >= lo && rises[i] + LAT <= hi) n++;
      return n;
   endfunction

   task automatic check_dut(input string nm, input int rs, input int g, input logic p_o,
                            input logic v_o, input logic [7:0] c_o, input logic s_o,
                            inout int cm, inout bit sm);
      logic ep;
      logic ev;
      int   cnt;
      int   n;
      ep = 1'b0;
      ev = 1'b0;
      if (rs < 0) begin
         sm = 1'b0;
      end else if (cyc - 1 > rs) begin
         cnt = (cyc - 2 - rs) % PMAX;
         ep  = cnt < pw_hist[cyc - 1 - cnt];
         if ((cyc - rs - 1) % g == 0 && cyc - rs - 1 >= g) begin
            ev = 1'b1;
            n  = win_count(rs, g, (cyc - rs - 1) / g - 1);
            cm = (n > 255) ? 255 : n;
            if (n > 255) sm = 1'b1;
         end
      end
      check({nm, " pwm_out"}, 32'(p_o), 32'(ep));
      check({nm, " c_valid"}, 32'(v_o), 32'(ev));
      check({nm, " C"}, 32'(c_o), cm);
      check({nm, " c_sat"}, 32'(s_o), 32'(sm));
   endtask

   // Record this cycle's inputs into the model, advance one clock, check both DUTs.
   task automatic tick();
      pw_hist[cyc] = int'(pw);
`ifdef TACH_FILTER_EN
      if (int'(tach) != flev) begin
         frun++;
         if (frun == FILT) begin
            flev = int'(tach);
            frun = 0;
            if (tach) rises.push_back(cyc - FILT + 1);
         end
      end else begin
         frun = 0;
      end
`else
      if (tach && !tach_prev) rises.push_back(cyc);
`endif
      tach_prev = tach;
      rs1 = !go ? -1 : ((rs1 < 0) ? cyc : rs1);
      rs2 = !go2 ? -1 : ((rs2 < 0) ? cyc : rs2);
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n) begin
         check_dut("dut", rs1, G1, pwm1, cv1, c1, sat1, cm1, sm1);
         check_dut("dut_long", rs2, G2, pwm2, cv2, c2, sat2, cm2, sm2);
         if (cv1 && first_cv1 < 0) first_cv1 = cyc;
      end
      if (tper > 0) tach = ((cyc - t0) % tper) < thigh;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) tick();
   endtask

   task automatic wait_valid(input int which, input int limit);
      int n = 1;
      tick();
      while (((which == 1) ? !cv1 : !cv2) && n < limit) begin
         tick();
         n++;
      end
      check((which == 1) ? "c_valid wait dut" : "c_valid wait dut_long",
            (which == 1) ? 32'(cv1) : 32'(cv2), 32'd1);
   endtask

   task automatic run_period(output int highs);
      highs = 0;
      repeat (PMAX) begin
         tick();
         highs += int'(pwm1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int g;
      int h;
      int e;
      int n;

      // Reset state
      #1;
      check("reset pwm_out", 32'(pwm1), 0);
      check("reset C", 32'(c1), 0);
      check("reset c_valid", 32'(cv1), 0);
      check("reset c_sat", 32'(sat1), 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // 1: pw=64, no tach
      pw = 8'd64;
      go = 1'b1;
      g  = cyc;
      tick();
      run_period(h);
      check("duty 64 highs", h, 64);
      check("first c_valid latency", first_cv1 - g - 1, G1);

      // 2: mid-period change takes effect next period; extremes
      h = 0;
      for (int j = 1; j <= PMAX; j++) begin
         tick();
         h += int'(pwm1);
         if (j == 100) pw = 8'd200;
      end
      check("pw change keeps current period", h, 64);
      run_period(h);
      check("pw 200 next period", h, 200);
      pw = 8'd0;
      run_period(h);
      check("pw 0 never high", h, 0);
      pw = 8'd255;
      run_period(h);
      check("pw 255 never low", h, 255);
      pw = 8'd100;

      // 3: periodic tach
      t0 = cyc; tper = 10; thigh = 5;
      wait_valid(1, 3 * G1);
      wait_valid(1, 3 * G1);
      check("tach period 10", 32'(c1), 10);
      wait_valid(1, 3 * G1);
      check("tach period 10 again", 32'(c1), 10);
      t0 = cyc; tper = 5; thigh = 2;
      wait_valid(1, 3 * G1);
      wait_valid(1, 3 * G1);
      check("tach period 5", 32'(c1), EXP_P5);

      // Single pulse detected on the last gate cycle, then one on the publish cycle
      tper = 0; tach = 1'b0;
      repeat (LAT + 12) tick();
      e = rs1 + ((cyc + LAT + 5 - rs1) / G1 + 1) * G1;
      wait_cyc(e - LAT);
      tach = 1'b1;
      repeat (HL) tick();
      tach = 1'b0;
      wait_cyc(e + 1);
      check("last-cycle edge valid", 32'(cv1), 1);
      check("last-cycle edge counts", 32'(c1), 1);
      wait_cyc(e + 1 + G1);
      check("next window empty", 32'(c1), 0);
      e = e + 2 * G1;
      wait_cyc(e + 1 - LAT);
      tach = 1'b1;
      repeat (HL) tick();
      tach = 1'b0;
      wait_cyc(e + 1);
      check("publish-cycle edge not in closing window", 32'(c1), 0);
      wait_cyc(e + 1 + G1);
      check("publish-cycle edge in next window", 32'(c1), 1);

      // 4: long gate, fast tach -> saturation; go low clears sticky flag
      go2 = 1'b1;
      t0 = cyc; tper = T4_PER; thigh = T4_PER / 2;
      wait_valid(2, 3 * G2);
      check("long window C", 32'(c2), T4_C);
      check("long window c_sat", 32'(sat2), T4_SAT);
      go2 = 1'b0;
      tick();
      check("go low clears c_sat", 32'(sat2), 0);
      check("go low stops pwm", 32'(pwm2), 0);

      // 5: async reset mid-window
      tper = 0; tach = 1'b0;
      repeat (LAT + 12) tick();
      n = 0;
      while ((cyc - rs1 - 1) % G1 != 50 && n < 2 * G1) begin
         tick();
         n++;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset pwm_out", 32'(pwm1), 0);
      check("async reset C", 32'(c1), 0);
      check("async reset c_valid", 32'(cv1), 0);
      check("async reset c_sat", 32'(sat1), 0);
      check("async reset long C", 32'(c2), 0);
      go = 1'b0; go2 = 1'b0;
      cm1 = 0; cm2 = 0; sm1 = 1'b0; sm2 = 1'b0;
      flev = 0; frun = 0;
      tick();
      tick();
      rst_n = 1'b1;
      go = 1'b1;
      go2 = 1'b1;
      g = cyc;
      first_cv1 = -1;
      wait_valid(1, 3 * G1);
      check("first c_valid after reset", first_cv1 - g - 1, G1);

`ifdef TACH_FILTER_EN
      // 6: glitch filter
      t0 = cyc; tper = 10; thigh = 2;
      wait_valid(1, 3 * G1);
      wait_valid(1, 3 * G1);
      check("filter drops 2-cycle glitches", 32'(c1), 0);
      t0 = cyc; tper = 20; thigh = 6;
      wait_valid(1, 3 * G1);
      wait_valid(1, 3 * G1);
      check("filter passes 6-cycle pulses", 32'(c1), 5);
`endif

      // Randomized segments, checked by the per-cycle model
      for (int s = 0; s < 6; s++) begin
         tper  = $urandom_range(12, 2);
         thigh = $urandom_range(tper - 1, 1);
         t0    = cyc;
         n     = $urandom_range(400, 150);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(49, 0) == 0) pw = 8'($urandom);
            tick();
         end
         if ($urandom_range(2, 0) == 0) begin
            go = 1'b0;
            tick();
            go = 1'b1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
